// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file.
// Optional WB->ID bypass is selected with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_e;

  // Bit offset of slice p in a vector packed from w-bit fields.
  function automatic int port_lsb(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: x0 forcing, ready gating and optional WB bypass.
// Bypass mux is present only when REGFILE_BYPASS_EN is defined.
module regfile_sb_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] arr_data,
  input  logic            pend_bit,
  input  logic            ready,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_addr,
  output logic [XLEN-1:0] rdata,
  output logic            pending
);

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wb_we, wb_addr, wb_data, issue_valid, issue_addr};
`endif

  always_comb begin
    rdata   = '0;
    pending = 1'b0;
    if (ready && addr != '0) begin
      rdata   = arr_data;
      pending = pend_bit;
`ifdef REGFILE_BYPASS_EN
      // A retiring write supersedes the array; a same-cycle reissue keeps it pending.
      if (wb_we && wb_addr == addr) begin
        rdata   = wb_data;
        pending = issue_valid && issue_addr == addr;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard and sequential clear sweep after reset.
// Define REGFILE_BYPASS_EN to forward WB data/pending clears to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NRD*AW-1:0] id_rs_addr,
  input  logic              id_issue_valid,
  input  logic [AW-1:0]     id_issue_rd_addr,
  input  logic              wb_q_is_rd_write,
  input  logic [AW-1:0]     wb_rd_addr,
  input  logic [XLEN-1:0]   wb_rd_wdata,
  output logic [NRD*XLEN-1:0] regfile_rs_rdata,
  output logic [NRD-1:0]    regfile_rs_pending,
  output logic              regfile_ready
);

  logic [XLEN-1:0]  arr [NREGS];
  logic [NREGS-1:0] pending_reg;
  logic [AW-1:0]    idx_reg;
  rf_state_e        state_reg, state_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= RF_INIT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == RF_INIT && idx_reg == AW'(NREGS - 1)) state_next = RF_READY;
  end

  // x0 is never swept: its reads are forced to zero at the ports.
  always_ff @(posedge clk_i) begin
    if (rst_i)                     idx_reg <= AW'(1);
    else if (state_reg == RF_INIT) idx_reg <= idx_reg + AW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_reg == RF_INIT)
        arr[idx_reg] <= '0;
      else if (wb_q_is_rd_write && wb_rd_addr != '0)
        arr[wb_rd_addr] <= wb_rd_wdata;
    end
  end

  // Set is assigned after clear so a same-cycle reissue keeps the bit set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_reg <= '0;
    end else if (state_reg == RF_READY) begin
      if (wb_q_is_rd_write && wb_rd_addr != '0) pending_reg[wb_rd_addr] <= 1'b0;
      if (id_issue_valid && id_issue_rd_addr != '0) pending_reg[id_issue_rd_addr] <= 1'b1;
    end
  end

  assign regfile_ready = (state_reg == RF_READY);

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] rs_addr;
    assign rs_addr = id_rs_addr[port_lsb(gi, AW) +: AW];

    regfile_sb_rdport #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_rdport (
      .addr       (rs_addr),
      .arr_data   (arr[rs_addr]),
      .pend_bit   (pending_reg[rs_addr]),
      .ready      (regfile_ready),
      .wb_we      (wb_q_is_rd_write),
      .wb_addr    (wb_rd_addr),
      .wb_data    (wb_rd_wdata),
      .issue_valid(id_issue_valid),
      .issue_addr (id_issue_rd_addr),
      .rdata      (regfile_rs_rdata[port_lsb(gi, XLEN) +: XLEN]),
      .pending    (regfile_rs_pending[gi])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: per-cycle model compare plus literal checks,
// and a second 16x64, 3-port instance.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: 32 x 32, 2 ports
  logic        rst = 1'b1;
  logic [9:0]  rs_addr = '0;
  logic        issue = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [63:0] rdata;
  logic [1:0]  pend;
  logic        ready;

  regfile_sb dut (
    .clk_i(clk), .rst_i(rst), .id_rs_addr(rs_addr),
    .id_issue_valid(issue), .id_issue_rd_addr(issue_rd),
    .wb_q_is_rd_write(wb_we), .wb_rd_addr(wb_addr), .wb_rd_wdata(wb_data),
    .regfile_rs_rdata(rdata), .regfile_rs_pending(pend), .regfile_ready(ready)
  );

  // Parametrised instance: 16 x 64, 3 ports
  logic         rst2 = 1'b1;
  logic [11:0]  rs_addr2 = '0;
  logic         wb_we2 = 1'b0;
  logic [3:0]   wb_addr2 = '0;
  logic [63:0]  wb_data2 = '0;
  logic [191:0] rdata2;
  logic [2:0]   pend2;
  logic         ready2;

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3)) dut2 (
    .clk_i(clk), .rst_i(rst2), .id_rs_addr(rs_addr2),
    .id_issue_valid(1'b0), .id_issue_rd_addr(4'd0),
    .wb_q_is_rd_write(wb_we2), .wb_rd_addr(wb_addr2), .wb_rd_wdata(wb_data2),
    .regfile_rs_rdata(rdata2), .regfile_rs_pending(pend2), .regfile_ready(ready2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: readiness by edge count, plain memory and pending array.
  logic        m_valid = 1'b0;
  logic        m_ready = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_mem [32];
  logic        m_pend [32];

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else if (m_valid) begin
      if (!m_ready) begin
        m_cnt++;
        if (m_cnt == 31) begin
          m_ready = 1'b1;
          for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        end
      end else begin
        if (wb_we && wb_addr != 0) begin
          m_mem[wb_addr]  = wb_data;
          m_pend[wb_addr] = 1'b0;
        end
        if (issue && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      end
    end
  end

  // Compare process: inputs change only at negedge+1, so negedge sees stable values.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready", {63'd0, ready}, {63'd0, m_ready});
      for (int p = 0; p < 2; p++) begin
        logic [4:0]  a;
        logic [31:0] ed;
        logic        ep;
        a  = rs_addr[p*5 +: 5];
        ed = 32'd0;
        ep = 1'b0;
        if (m_ready && a != 0) begin
          ed = m_mem[a];
          ep = m_pend[a];
`ifdef REGFILE_BYPASS_EN
          if (wb_we && wb_addr == a) begin
            ed = wb_data;
            ep = issue && issue_rd == a;
          end
`endif
        end
        chk($sformatf("rdata%0d", p), {32'd0, rdata[p*32 +: 32]}, {32'd0, ed});
        chk($sformatf("pend%0d", p), {63'd0, pend[p]}, {63'd0, ep});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic count_to_ready(input string name, input int exp_edges);
    int n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    chk(name, 64'(n), 64'(exp_edges));
  endtask

  initial begin
    // Reset sweep and defaults
    repeat (3) tick();
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_pend", {62'd0, pend}, 64'd0);
    rst = 1'b0;
    rs_addr = {5'd9, 5'd1};
    count_to_ready("ready_edges", 31);

    // Reset at sweep index 10: ready must come 31 edges after release
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (9) tick();
    chk("mid_not_ready", {63'd0, ready}, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_to_ready("mid_reset_edges", 31);

    // Write/read and x0
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_addr = 5'd0; wb_data = 32'h12345678;
    tick();
    wb_we = 1'b0;
    rs_addr = {5'd0, 5'd5};
    #1;
    chk("x5_read", {32'd0, rdata[31:0]}, 64'h0000_0000_DEAD_BEEF);
    chk("x0_read", {32'd0, rdata[63:32]}, 64'd0);

    // Scoreboard on x7
    rs_addr = {5'd5, 5'd7};
    issue = 1'b1; issue_rd = 5'd7;
    tick();
    issue = 1'b0;
    #1;
    chk("x7_pend_set", {63'd0, pend[0]}, 64'd1);
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h1111_1111;
    tick();
    wb_we = 1'b0;
    #1;
    chk("x7_pend_clr", {63'd0, pend[0]}, 64'd0);
    chk("x7_data", {32'd0, rdata[31:0]}, 64'h1111_1111);
    issue = 1'b1; wb_we = 1'b1; wb_data = 32'h2222_2222;
    tick();
    issue = 1'b0; wb_we = 1'b0;
    #1;
    chk("x7_set_wins", {63'd0, pend[0]}, 64'd1);
    chk("x7_data2", {32'd0, rdata[31:0]}, 64'h2222_2222);

    // Bypass (or its absence) on x3
    rs_addr = {5'd0, 5'd3};
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    issue = 1'b1; issue_rd = 5'd3;
    tick();
    issue = 1'b0;
    wb_data = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", {32'd0, rdata[31:0]}, 64'hA5A5A5A5);
    chk("byp_pend", {63'd0, pend[0]}, 64'd0);
`else
    chk("nobyp_data", {32'd0, rdata[31:0]}, 64'h11);
    chk("nobyp_pend", {63'd0, pend[0]}, 64'd1);
`endif
    tick();
    wb_we = 1'b0;
    #1;
    chk("x3_after_data", {32'd0, rdata[31:0]}, 64'hA5A5A5A5);
    chk("x3_after_pend", {63'd0, pend[0]}, 64'd0);

    // Reset in READY restarts the sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ready_rst_drop", {63'd0, ready}, 64'd0);
    count_to_ready("ready_rst_edges", 31);

    // Parametrised instance
    rst2 = 1'b0;
    begin
      int n = 0;
      while (!ready2 && n < 100) begin
        tick();
        n++;
      end
      chk("p16_ready_edges", 64'(n), 64'd15);
    end
    wb_we2 = 1'b1; wb_addr2 = 4'd15; wb_data2 = 64'h0123456789ABCDEF;
    tick();
    wb_we2 = 1'b0;
    rs_addr2 = {4'd15, 4'd15, 4'd15};
    #1;
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("p16_rd%0d", p), rdata2[p*64 +: 64], 64'h0123456789ABCDEF);
    end
    chk("p16_pend", {61'd0, pend2}, 64'd0);
    rs_addr2 = {4'd0, 4'd15, 4'd0};
    #1;
    chk("p16_x0", {rdata2[191:128], rdata2[63:0]} == 128'd0 ? 64'd1 : 64'd0, 64'd1);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
